mat_result_serializer: RTL and testbench

Downstream stage of the 3x3 matrix multiplier. Captures the nine parallel result words (o11..o33) when the controller pulses `done`, then streams them out one per cycle in row-major order over a valid/ready handshake. The multiplier can start the next product while the previous one drains. Overrun, meaning a new `done` while a matrix is still draining, is flagged, not silently merged.

---
 rtl/mat_result_serializer_pkg.sv | 18 +
 rtl/mat_result_serializer_if.sv | 34 +++
 rtl/mat_result_serializer_rowcol_counter.sv | 50 +++++
 rtl/mat_result_serializer.sv | 120 ++++++++++++
 tb/tb_mat_result_serializer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mat_result_serializer_pkg.sv
// Shared constants and types for the 3x3 matrix result serializer.
// Result width covers the sum of three DATA_W x DATA_W products.
package mat_result_serializer_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned RES_W     = 2 * DATA_W + 2;
  localparam int unsigned MAT_N     = 3;
  localparam int unsigned MAT_ELEMS = MAT_N * MAT_N;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  typedef logic [RES_W-1:0] res_t;

endpackage : mat_result_serializer_pkg

// File: rtl/mat_result_serializer_if.sv
// Valid/ready output stream of the result serializer, with element coordinates.
// master = serializer side, slave = consumer side.
interface mat_result_serializer_if
  import mat_result_serializer_pkg::*;
#(
  parameter int unsigned ResW = RES_W
) ();

  logic [ResW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface : mat_result_serializer_if

// File: rtl/mat_result_serializer_rowcol_counter.sv
// Row/column position counter over an MAT_N x MAT_N matrix in row-major order.
// Clear has priority over enable; last flags the bottom-right element.
module rowcol_counter
  import mat_result_serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] row_o,
  output logic [1:0] col_o,
  output logic       last_o
);

  localparam logic [1:0] MaxIdx = 2'(MAT_N - 1);

  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == MaxIdx) begin
        col_d = '0;
        row_d = (row_q == MaxIdx) ? 2'd0 : row_q + 2'd1;
      end else begin
        col_d = col_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == MaxIdx) && (col_q == MaxIdx);

endmodule : rowcol_counter

// File: rtl/mat_result_serializer.sv
// Captures nine parallel result words on done and streams them row-major over
// valid/ready. A done arriving mid-drain is dropped and flagged as overrun.
module mat_result_serializer
  import mat_result_serializer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       done,
  input  logic [MAT_ELEMS*RES_W-1:0] res_in,
  input  logic                       clr_ovr,
  output logic                       busy,
  output logic                       overrun,
  mat_result_serializer_if.master    out_if
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(MAT_ELEMS - 1);

  state_e           state_q, state_d;
  res_t             buf_q [MAT_ELEMS];
  res_t             buf_d [MAT_ELEMS];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovr_q, ovr_d;

  logic       hs, final_hs, load, ovr_set;
  logic       rc_clr, rc_en;
  logic [1:0] row, col;
  logic       last;

  rowcol_counter u_rowcol_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (rc_clr),
    .en_i   (rc_en),
    .row_o  (row),
    .col_o  (col),
    .last_o (last)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    ovr_d    = ovr_q;
    rc_clr   = 1'b0;
    rc_en    = 1'b0;
    load     = 1'b0;
    ovr_set  = 1'b0;
    hs       = (state_q == StSend) && out_if.out_ready;
    final_hs = hs && (idx_q == LastIdx);

    unique case (state_q)
      StIdle: begin
        if (done) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (final_hs) begin
          // A done coinciding with the last handshake chains straight into the next matrix.
          if (done) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            idx_d   = '0;
            rc_clr  = 1'b1;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 4'd1;
            rc_en = 1'b1;
          end
          if (done) begin
            ovr_set = 1'b1;
          end
        end
      end
    endcase

    if (load) begin
      for (int k = 0; k < MAT_ELEMS; k++) begin
        buf_d[k] = res_in[k*RES_W +: RES_W];
      end
      idx_d  = '0;
      rc_clr = 1'b1;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < MAT_ELEMS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode registered state only; out_ready never reaches them combinationally.
  assign out_if.out_valid = (state_q == StSend);
  assign out_if.out_data  = (state_q == StSend) ? buf_q[idx_q] : '0;
  assign out_if.out_row   = row;
  assign out_if.out_col   = col;
  assign out_if.out_last  = (state_q == StSend) && last;
  assign busy             = (state_q == StSend);
  assign overrun          = ovr_q;

endmodule : mat_result_serializer

// File: tb/tb_mat_result_serializer.sv
// Directed and randomized bench for mat_result_serializer against a queue-based
// model: pending words drain from the front, position gives row/col.
module tb_mat_result_serializer;
  import mat_result_serializer_pkg::*;

  localparam int unsigned BusW = MAT_ELEMS * RES_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            done = 1'b0;
  logic            clr_ovr = 1'b0;
  logic [BusW-1:0] res_in = '0;
  logic            busy;
  logic            overrun;

  mat_result_serializer_if bus ();

  mat_result_serializer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .done    (done),
    .res_in  (res_in),
    .clr_ovr (clr_ovr),
    .busy    (busy),
    .overrun (overrun),
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned exp_q[$];
  bit          exp_ovr = 1'b0;

  logic [BusW-1:0] d1, d675, dtmp;

  function automatic logic [BusW-1:0] pack(input int unsigned w[9]);
    logic [BusW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*RES_W +: RES_W] = RES_W'(w[k]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit          v;
    int unsigned pos;
    v   = (exp_q.size() != 0);
    pos = MAT_ELEMS - exp_q.size();
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".busy"}, 32'(busy), 32'(v));
    chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    chk({tag, ".data"}, 32'(bus.out_data), v ? exp_q[0] : 32'd0);
    chk({tag, ".row"}, 32'(bus.out_row), v ? pos / MAT_N : 32'd0);
    chk({tag, ".col"}, 32'(bus.out_col), v ? pos % MAT_N : 32'd0);
    chk({tag, ".last"}, 32'(bus.out_last), 32'(v && exp_q.size() == 1));
  endtask

  // Model effect of one clock edge given the inputs that were applied before it.
  task automatic model_edge(input bit rdy, input bit dn, input bit clr,
                            input logic [BusW-1:0] data);
    bit sending, fin, set;
    sending = (exp_q.size() != 0);
    fin     = 1'b0;
    set     = 1'b0;
    if (sending && rdy) begin
      fin = (exp_q.size() == 1);
      void'(exp_q.pop_front());
    end
    if (dn) begin
      if (!sending || fin) begin
        for (int k = 0; k < MAT_ELEMS; k++) exp_q.push_back(int'(data[k*RES_W +: RES_W]));
      end else begin
        set = 1'b1;
      end
    end
    if (set) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
  endtask

  task automatic step(input string tag, input bit rdy, input bit dn, input bit clr,
                      input logic [BusW-1:0] data);
    bus.out_ready = rdy;
    done          = dn;
    clr_ovr       = clr;
    res_in        = data;
    @(posedge clk);
    model_edge(rdy, dn, clr, data);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int unsigned t1[9];
    int unsigned t675[9];
    int unsigned tr[9];
    int          n;
    t1   = '{66, 57, 37, 141, 117, 74, 107, 59, 26};
    t675 = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
    d1   = pack(t1);
    d675 = pack(t675);
    bus.out_ready = 1'b0;

    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    // Full-rate drain of the reference matrix, then one idle cycle.
    step("t1_load", 1'b1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 9; i++) step("t1_drain", 1'b1, 1'b0, 1'b0, '0);

    // Ready toggling 1,0,0 until drained.
    step("t2_load", 1'b1, 1'b1, 1'b0, d1);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step("t2_drain", (n % 3) == 0, 1'b0, 1'b0, '0);
      n++;
    end
    chk("t2_bound", 32'(exp_q.size()), 32'd0);

    // Overrun at idx 4: new matrix dropped.
    step("t3_load", 1'b1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 4; i++) step("t3_adv", 1'b1, 1'b0, 1'b0, '0);
    chk("t3_idx4", 32'(bus.out_data), 32'd117);
    step("t3_ovr", 1'b0, 1'b1, 1'b0, d675);
    for (int i = 0; i < 6; i++) step("t3_drain", 1'b1, 1'b0, 1'b0, '0);
    step("t3_clr", 1'b0, 1'b0, 1'b1, '0);

    // Back-to-back: done on the final handshake.
    step("t4_load", 1'b1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 8; i++) step("t4_adv", 1'b1, 1'b0, 1'b0, '0);
    step("t4_chain", 1'b1, 1'b1, 1'b0, d675);
    for (int i = 0; i < 9; i++) step("t4_drain", 1'b1, 1'b0, 1'b0, '0);

    // Clear colliding with an overrun-setting done: set wins.
    step("t5_load", 1'b1, 1'b1, 1'b0, d1);
    step("t5_setclr", 1'b0, 1'b1, 1'b1, d675);
    step("t5_clr", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 9; i++) step("t5_drain", 1'b1, 1'b0, 1'b0, '0);

    // Asynchronous reset at idx 5, away from any clock edge.
    step("t6_load", 1'b1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 5; i++) step("t6_adv", 1'b1, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    check_outputs("t6_async_rst");
    #2;
    rst_n = 1'b1;
    step("t6_idle", 1'b1, 1'b0, 1'b0, '0);
    step("t6_restart", 1'b1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 9; i++) step("t6_drain", 1'b1, 1'b0, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 9; k++) tr[k] = $urandom_range(0, 1023);
      dtmp = pack(tr);
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) == 0, dtmp);
    end

    done    = 1'b0;
    clr_ovr = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mat_result_serializer
